// File: rtl/wash_cycle_controller.sv
// -----------------------------------------------------------------------------
// wash_cycle_controller
//
// Moore FSM that sequences one washing-machine program:
//   FILL -> WASH -> DRAIN -> (RFILL -> RINSE -> RDRAIN) x NUM_RINSE -> SPIN -> DONE
// It drives the shared phase timer (timer_R restart strobe, timer_load size) and
// consumes the timer's terminal flags. Door-open pause, abort and invalid-load
// fault handling live here.
//
// Ports:
//   clk          rising-edge system clock
//   reset        asynchronous, active-high reset
//   start        level; sampled only in IDLE, PAUSE and DONE
//   abort        level; returns to IDLE from any state
//   door_closed  1 = door closed
//   load_sel     load size 00 small, 01 medium, 10 large, 11 invalid
//   Td/Tf/Tr/Ts/Tw  timer terminal flags for drain/fill/rinse/spin/wash
//   timer_R      registered synchronous clear to the timer
//   timer_load   load size latched at program start
//   water_valve, agitate, drain_pump, spin_motor, door_lock, done, fault
//                Moore decode of the state register
//   state        current state code (debug)
// -----------------------------------------------------------------------------
module wash_cycle_controller #(
    parameter int unsigned NUM_RINSE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       door_closed,
    input  logic [1:0] load_sel,
    input  logic       Td,
    input  logic       Tf,
    input  logic       Tr,
    input  logic       Ts,
    input  logic       Tw,
    output logic       timer_R,
    output logic [1:0] timer_load,
    output logic       water_valve,
    output logic       agitate,
    output logic       drain_pump,
    output logic       spin_motor,
    output logic       door_lock,
    output logic       done,
    output logic       fault,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FILL   = 4'd1,
        S_WASH   = 4'd2,
        S_DRAIN  = 4'd3,
        S_RFILL  = 4'd4,
        S_RINSE  = 4'd5,
        S_RDRAIN = 4'd6,
        S_SPIN   = 4'd7,
        S_DONE   = 4'd8,
        S_PAUSE  = 4'd9,
        S_FAULT  = 4'd10
    } state_e;

    localparam logic [1:0] RINSE_TARGET = NUM_RINSE[1:0];

    state_e     state_q, state_d;
    state_e     saved_q, saved_d;
    logic       timer_r_q, timer_r_d;
    logic [1:0] timer_load_q, timer_load_d;
    logic [1:0] rinse_cnt_q, rinse_cnt_d;
    logic [1:0] rinse_next_s;
    logic       phase_flag_s;
    state_e     next_phase_s;

    // Active phases are the ones that run the timer and lock the door.
    function automatic logic is_active(input state_e s);
        logic r;
        case (s)
            S_FILL, S_WASH, S_DRAIN, S_RFILL, S_RINSE, S_RDRAIN, S_SPIN: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign rinse_next_s = rinse_cnt_q + 2'd1;

    // Terminal flag belonging to the current phase and the phase that follows it.
    always_comb begin
        phase_flag_s = 1'b0;
        next_phase_s = S_IDLE;
        case (state_q)
            S_FILL: begin
                phase_flag_s = Tf;
                next_phase_s = S_WASH;
            end
            S_WASH: begin
                phase_flag_s = Tw;
                next_phase_s = S_DRAIN;
            end
            S_DRAIN: begin
                phase_flag_s = Td;
                next_phase_s = S_RFILL;
            end
            S_RFILL: begin
                phase_flag_s = Tf;
                next_phase_s = S_RINSE;
            end
            S_RINSE: begin
                phase_flag_s = Tr;
                next_phase_s = S_RDRAIN;
            end
            S_RDRAIN: begin
                phase_flag_s = Td;
                // Compare the already-incremented count so the last pass goes to SPIN.
                next_phase_s = (rinse_next_s == RINSE_TARGET) ? S_SPIN : S_RFILL;
            end
            S_SPIN: begin
                phase_flag_s = Ts;
                next_phase_s = S_DONE;
            end
            default: begin
                phase_flag_s = 1'b0;
                next_phase_s = S_IDLE;
            end
        endcase
    end

    // Next-state, saved-phase, rinse-count, load latch and timer restart logic.
    always_comb begin
        state_d      = state_q;
        saved_d      = saved_q;
        rinse_cnt_d  = rinse_cnt_q;
        timer_load_d = timer_load_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start && (load_sel == 2'b11)) begin
                        state_d = S_FAULT;
                    end else if (start && door_closed) begin
                        state_d      = S_FILL;
                        timer_load_d = load_sel;
                        rinse_cnt_d  = 2'd0;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_FILL, S_WASH, S_DRAIN, S_RFILL, S_RINSE, S_RDRAIN, S_SPIN: begin
                    // Door-open outranks a terminal flag; the current phase is saved.
                    if (!door_closed) begin
                        state_d = S_PAUSE;
                        saved_d = state_q;
                    end else if (phase_flag_s && !timer_r_q) begin
                        // Flags seen while timer_R=1 are stale counts and are masked.
                        state_d = next_phase_s;
                        if (state_q == S_RDRAIN) begin
                            rinse_cnt_d = rinse_next_s;
                        end else begin
                            rinse_cnt_d = rinse_cnt_q;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                S_PAUSE: begin
                    if (start && door_closed) begin
                        state_d = saved_q;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        // Timer is held clear outside active phases and pulsed on every phase entry,
        // including a resume from PAUSE and the RDRAIN -> RFILL loop.
        timer_r_d = (state_d != state_q) || !is_active(state_d);
    end

    // State and control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            saved_q      <= S_FILL;
            timer_r_q    <= 1'b1;
            timer_load_q <= 2'b00;
            rinse_cnt_q  <= 2'd0;
        end else begin
            state_q      <= state_d;
            saved_q      <= saved_d;
            timer_r_q    <= timer_r_d;
            timer_load_q <= timer_load_d;
            rinse_cnt_q  <= rinse_cnt_d;
        end
    end

    // Moore decode of actuators and status from the state register.
    always_comb begin
        water_valve = 1'b0;
        agitate     = 1'b0;
        drain_pump  = 1'b0;
        spin_motor  = 1'b0;
        done        = 1'b0;
        fault       = 1'b0;
        door_lock   = is_active(state_q);
        case (state_q)
            S_FILL, S_RFILL:  water_valve = 1'b1;
            S_WASH, S_RINSE:  agitate     = 1'b1;
            S_DRAIN, S_RDRAIN: drain_pump = 1'b1;
            S_SPIN: begin
                drain_pump = 1'b1;
                spin_motor = 1'b1;
            end
            S_DONE:  done  = 1'b1;
            S_FAULT: fault = 1'b1;
            default: begin
                water_valve = 1'b0;
                agitate     = 1'b0;
            end
        endcase
    end

    assign timer_R    = timer_r_q;
    assign timer_load = timer_load_q;
    assign state      = state_q;

endmodule

// File: doc/wash_cycle_controller.md
Name: wash_cycle_controller

Overview:
Moore FSM that sequences one complete washing-machine program: fill, wash, drain, NUM_RINSE rinse passes, then spin. It drives the shared phase timer (restart strobe and load size), consumes the timer's terminal flags, and drives the actuator outputs. Door-open pause, abort, and invalid-load fault handling live here.

Parameters:
NUM_RINSE, 1, number of rinse passes (fill/rinse/drain triplets); legal 1..3, stored in a 2-bit counter.

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  level; sampled only in IDLE, PAUSE, DONE
abort  input  1  level; returns the FSM to IDLE from any state
door_closed  input  1  1 = door closed
load_sel  input  2  load size: 00 small, 01 medium, 10 large, 11 invalid
Td  input  1  timer flag, count==1 (drain)
Tf  input  1  timer flag, count==2 (fill)
Tr  input  1  timer flag, count==4 (rinse)
Ts  input  1  timer flag, count==7 (spin)
Tw  input  1  timer flag, count==2/4/8 for load 00/01/10 (wash)
timer_R  output  1  registered synchronous clear to the timer
timer_load  output  2  latched load size to the timer
water_valve  output  1  active in FILL, RFILL
agitate  output  1  active in WASH, RINSE
drain_pump  output  1  active in DRAIN, RDRAIN, SPIN
spin_motor  output  1  active in SPIN
door_lock  output  1  active in FILL through SPIN
done  output  1  active in DONE
fault  output  1  active in FAULT
state  output  4  current state code (debug)

Behaviour:
- States and codes: IDLE=0, FILL=1, WASH=2, DRAIN=3, RFILL=4, RINSE=5, RDRAIN=6, SPIN=7, DONE=8, PAUSE=9, FAULT=10. Codes 11..15 are illegal and go to IDLE on the next edge.
- Reset (async) forces: state=IDLE, timer_R=1, timer_load=00, rinse count=0, saved phase=FILL. All actuators, done, and fault are 0.
- Actuator, done, and fault outputs are a pure Moore decode of the state register.
- timer_R is registered. It is 1 continuously in IDLE, DONE, PAUSE, FAULT. It is 1 for exactly the first cycle of each active phase and 0 thereafter.
- Timer flags are ignored in any cycle where timer_R=1, which masks stale counts. A phase exits on the first edge where its flag=1 and timer_R=0.
- Phase length: terminal count N+2 cycles. Resulting lengths: FILL 4, WASH 4/6/10 (load 00/01/10), DRAIN 3, RFILL 4, RINSE 6, RDRAIN 3, SPIN 9.
- IDLE exits:
  - start=1, door_closed=1, load_sel!=11 → FILL. Latch load_sel into timer_load; clear the rinse count.
  - start=1, load_sel=11 → FAULT.
  - start=1, door_closed=0 → stay in IDLE.
- Normal sequence: FILL→WASH→DRAIN→RFILL→RINSE→RDRAIN.
- RDRAIN exit: increment the rinse count. Go to SPIN if the incremented count equals NUM_RINSE, else go to RFILL.
- SPIN exits to DONE.
- DONE holds done=1. start with door_closed=1 and valid load begins a new program (same rules as IDLE).
- Pause: door_closed=0 in any active phase (FILL..SPIN) → PAUSE on the next edge.
  - The phase being left is saved; the rinse count is kept.
  - PAUSE exits only on start=1 with door_closed=1, back to the saved phase.
  - The resumed phase restarts from zero (timer_R pulse, full length).
- FAULT: fault=1 and it is sticky. Exit only by abort or reset.
- abort=1 → IDLE on the next edge from every state. Priority: reset > abort > door-open > flag/start.
- Simultaneous door-open and phase flag in the same cycle → PAUSE wins; the saved phase is the current phase, not its successor.
- load_sel changes after start are ignored until the next program start.

Test Plan:
- NUM_RINSE=1, load 00, door closed, start pulse at edge s → state sequence 1,2,3,4,5,6,7. DONE at edge s+33; done=1 thereafter. timer_R=1 in exactly the first cycle of each phase.
- Load 10, NUM_RINSE=1 → WASH lasts 10 cycles, DONE at s+39. timer_load=10 through the whole program, even with load_sel changed to 00 mid-run.
- NUM_RINSE=2, load 00 → RFILL/RINSE/RDRAIN appear twice, DONE at s+46, rinse count wraps correctly.
- door_closed=0 during the 2nd cycle of WASH → PAUSE next edge, all actuators 0, timer_R=1. Door closed plus start → WASH restarts for a full 4 cycles, then DRAIN.
- start with load_sel=11 → FAULT, fault=1. start is ignored. abort → IDLE, fault=0.
- Assert reset mid-SPIN asynchronously → state=0, spin_motor=0, timer_R=1 immediately. abort during RINSE → IDLE next edge.
